pwm_capture: RTL and testbench
==============================

PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 BITS, default 16, width of period/high-time counters and outputs.
REQ-002 clk_i  input  1  single clock, all state on rising edge.
REQ-003 rst_i  input  1  asynchronous, active-high reset.
REQ-004 enable  input  1  measurement enable, synchronous to clk_i.
REQ-005 pwm_i  input  1  PWM waveform to measure, may be asynchronous to clk_i.
REQ-006 period_o  output  BITS  last measured period in clk_i cycles, rising edge to rising edge.
REQ-007 high_o  output  BITS  last measured high time in clk_i cycles.
REQ-008 valid_o  output  1  one-cycle pulse when period_o/high_o update.
REQ-009 overflow_o  output  1  one-cycle pulse when the counter saturates without a rising edge.

Function
REQ-010 The block SHALL derive the sampled level s from pwm_i through the input stage defined under Configuration, plus one edge register q<=s; rise = s & ~q, fall = ~s & q.
REQ-011 The block SHALL implement states IDLE, ARM and MEAS with a BITS-wide cycle counter cnt and a BITS-wide high-time capture register hcap.
REQ-012 IDLE: cnt=0; enable=1 moves to ARM next cycle.
REQ-013 ARM: waits for rise; on rise, cnt<=1 and state<=MEAS; no valid_o; a partial first period is never reported.
REQ-014 MEAS, no edge: cnt<=cnt+1.
REQ-015 MEAS, fall: hcap<=cnt, cnt<=cnt+1.
REQ-016 MEAS, rise: period_o<=cnt, high_o<=hcap, valid_o<=1 for one cycle, cnt<=1, stay in MEAS.
REQ-017 Counting rule: a pwm_i waveform high H cycles, period P cycles, SHALL report high_o=H and period_o=P exactly.
REQ-018 MEAS, cnt=2^BITS-1 and no rise: overflow_o<=1 for one cycle, cnt<=0, state<=ARM; period_o/high_o unchanged.
REQ-019 Rise in the same cycle as cnt=2^BITS-1 SHALL take priority over overflow: period_o=2^BITS-1 reported, no overflow_o.
REQ-020 enable=0 in any state SHALL force IDLE next cycle, cnt<=0, and suppress valid_o/overflow_o that cycle; period_o/high_o hold.
REQ-021 0%/100% duty (no edges) SHALL produce no valid_o and, once in MEAS, overflow_o after 2^BITS-1 counted cycles.
REQ-022 A one-clock high glitch seen after the input stage SHALL be measured as high_o=1.
REQ-023 valid_o and overflow_o SHALL never be asserted in the same cycle.

Reset
REQ-024 rst_i=1 SHALL immediately force state=IDLE, cnt=0, hcap=0, period_o=0, high_o=0, valid_o=0, overflow_o=0, and all input-stage and edge registers to 0.
REQ-025 Reset deasserted mid-waveform SHALL behave as power-up: IDLE, then ARM, first report after two rising edges seen in ARM/MEAS.

Configuration
REQ-026 Macro PWM_CAPTURE_SYNC_EN defined: input stage SHALL be a two-flop synchronizer; valid_o asserts on the 3rd clk_i edge after the first edge sampling pwm_i high.
REQ-027 Macro PWM_CAPTURE_SYNC_EN undefined: input stage SHALL be a single register; valid_o asserts on the 2nd such edge; measured values identical in both builds.

Verification
REQ-028 BITS=16, enable=1, pwm_i P=10 H=3 repeated -> first valid_o after second rise, period_o=10, high_o=3, valid_o every 10 cycles.
REQ-029 Switch waveform to P=7 H=6 mid-run -> first valid after change reports a mixed period, subsequent valids report period_o=7, high_o=6.
REQ-030 BITS=4, one rise then pwm_i held high -> overflow_o single pulse 15 cycles after entering MEAS, state ARM, outputs unchanged, no valid_o.
REQ-031 BITS=4, P=15 H=1 -> period_o=15, high_o=1, no overflow_o.
REQ-032 enable dropped for 5 cycles mid-period, then P=10 H=4 -> no valid_o while low; after re-enable, first valid_o only after two rises, values 10/4.
REQ-033 rst_i pulsed asynchronously mid-high-time -> all outputs 0 immediately; both macro builds checked for REQ-026/027 latency.

Source files
------------

// File: rtl/pwm_capture_if.sv
// PWM capture bus: measurement controls in, measurement results out.
// The capture core connects through the slave modport. Whoever drives
// enable/pwm_i and consumes the results uses the master modport.
interface pwm_capture_if #(
  parameter int BITS = 16
) ();

  logic            enable;
  logic            pwm_i;
  logic [BITS-1:0] period_o;
  logic [BITS-1:0] high_o;
  logic            valid_o;
  logic            overflow_o;

  modport master (
    output enable,
    output pwm_i,
    input  period_o,
    input  high_o,
    input  valid_o,
    input  overflow_o
  );

  modport slave (
    input  enable,
    input  pwm_i,
    output period_o,
    output high_o,
    output valid_o,
    output overflow_o
  );

endinterface

// File: rtl/pwm_capture.sv
// pwm_capture: measures the period and high time of a PWM waveform in clk_i
// cycles, rising edge to rising edge.
//
// Build option: define PWM_CAPTURE_SYNC_EN to put a two-flop synchronizer in
// front of the edge detector. This is needed when pwm_i is asynchronous to
// clk_i. Without the macro, the input stage is a single register. The
// measured values are the same in both builds. Only the report latency
// changes, by one cycle.
//
// A measurement is reported only after two rising edges seen while armed or
// measuring, so a partial first period never appears on period_o.
// overflow_o pulses when the counter reaches its maximum without a rising
// edge. The block then re-arms and waits for a fresh rising edge.
module pwm_capture #(
  parameter int BITS = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  pwm_capture_if.slave bus
);

`ifdef PWM_CAPTURE_SYNC_EN
  localparam int STAGES = 2;
`else
  localparam int STAGES = 1;
`endif

  localparam logic [BITS-1:0] CNT_ONE = {{(BITS-1){1'b0}}, 1'b1};
  localparam logic [BITS-1:0] CNT_MAX = {BITS{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_MEAS = 2'd2
  } state_t;

  // ---------------------------------------------------------------------
  // Input stage and edge detection
  // ---------------------------------------------------------------------
  logic [STAGES-1:0] stage_reg;
  logic [STAGES-1:0] stage_next;
  logic              level_s;
  logic              edge_reg;
  logic              rise;
  logic              fall;

  // Stage 0 samples the raw pin. Each later stage copies the one before it.
  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        assign stage_next[gi] = bus.pwm_i;
      end else begin : g_chain
        assign stage_next[gi] = stage_reg[gi-1];
      end
    end
  endgenerate

  // Register the synchronizer chain.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stage_reg <= '0;
    end else begin
      stage_reg <= stage_next;
    end
  end

  assign level_s = stage_reg[STAGES-1];

  // Hold the previous sampled level for edge detection.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      edge_reg <= 1'b0;
    end else begin
      edge_reg <= level_s;
    end
  end

  assign rise = level_s & ~edge_reg;
  assign fall = ~level_s & edge_reg;

  // ---------------------------------------------------------------------
  // Control FSM and measurement datapath
  // ---------------------------------------------------------------------
  state_t          state_reg;
  state_t          state_next;
  logic [BITS-1:0] cnt_reg;
  logic [BITS-1:0] cnt_next;
  logic [BITS-1:0] hcap_reg;
  logic [BITS-1:0] hcap_next;
  logic [BITS-1:0] period_reg;
  logic [BITS-1:0] period_next;
  logic [BITS-1:0] high_reg;
  logic [BITS-1:0] high_next;
  logic            valid_reg;
  logic            valid_next;
  logic            overflow_reg;
  logic            overflow_next;
  logic            cnt_max;

  assign cnt_max = (cnt_reg == CNT_MAX);

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic. Dropping enable always returns to IDLE. A rising edge
  // wins over saturation, so a period of exactly CNT_MAX is still reported.
  always_comb begin
    state_next = state_reg;
    if (!bus.enable) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: state_next = ST_ARM;
        ST_ARM:  if (rise) state_next = ST_MEAS;
        ST_MEAS: if (!rise && cnt_max) state_next = ST_ARM;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Datapath and output pulses for the current state. cnt is 1 in the
  // cycle after the rise is acted on, so on the next rise it equals the
  // period exactly. On the fall it equals the high time exactly.
  always_comb begin
    cnt_next      = cnt_reg;
    hcap_next     = hcap_reg;
    period_next   = period_reg;
    high_next     = high_reg;
    valid_next    = 1'b0;
    overflow_next = 1'b0;
    if (!bus.enable) begin
      cnt_next = '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          cnt_next = '0;
        end
        ST_ARM: begin
          if (rise) begin
            cnt_next = CNT_ONE;
          end
        end
        ST_MEAS: begin
          if (rise) begin
            period_next = cnt_reg;
            high_next   = hcap_reg;
            valid_next  = 1'b1;
            cnt_next    = CNT_ONE;
          end else if (cnt_max) begin
            overflow_next = 1'b1;
            cnt_next      = '0;
          end else begin
            cnt_next = cnt_reg + CNT_ONE;
            if (fall) begin
              hcap_next = cnt_reg;
            end
          end
        end
        default: begin
          cnt_next = '0;
        end
      endcase
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_reg      <= '0;
      hcap_reg     <= '0;
      period_reg   <= '0;
      high_reg     <= '0;
      valid_reg    <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      cnt_reg      <= cnt_next;
      hcap_reg     <= hcap_next;
      period_reg   <= period_next;
      high_reg     <= high_next;
      valid_reg    <= valid_next;
      overflow_reg <= overflow_next;
    end
  end

  assign bus.period_o   = period_reg;
  assign bus.high_o     = high_reg;
  assign bus.valid_o    = valid_reg;
  assign bus.overflow_o = overflow_reg;

endmodule

// File: tb/tb_pwm_capture.sv
// Testbench for pwm_capture. Two instances (BITS=16 and BITS=4) see the same
// waveform. A timestamp-based reference model predicts each report or
// overflow. Monitors compare those predictions against the DUT outputs.
`timescale 1ns/1ps
module tb_pwm_capture;

`ifdef PWM_CAPTURE_SYNC_EN
  localparam int D = 2;
`else
  localparam int D = 1;
`endif

  typedef struct {
    int     mode;     // 0 idle, 1 armed, 2 measuring
    longint rise_t;
    longint fall_t;
    longint last_p;
    longint last_h;
  } mdl_t;

  typedef struct {
    bit     ovf;
    longint p;
    longint h;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_i;
  logic pwm;
  logic en;

  always #5 clk_i = ~clk_i;

  pwm_capture_if #(.BITS(16)) bus16 ();
  pwm_capture_if #(.BITS(4))  bus4 ();

  assign bus16.enable = en;
  assign bus16.pwm_i  = pwm;
  assign bus4.enable  = en;
  assign bus4.pwm_i   = pwm;

  pwm_capture #(.BITS(16)) u16 (.clk_i(clk_i), .rst_i(rst_i), .bus(bus16));
  pwm_capture #(.BITS(4))  u4  (.clk_i(clk_i), .rst_i(rst_i), .bus(bus4));

  int     n_vec = 0;
  int     n_err = 0;
  int     n_valid_seen = 0;
  int     n_ovf4_seen = 0;
  mdl_t   m16;
  mdl_t   m4;
  exp_t   q16[$];
  exp_t   q4[$];
  logic [3:0] hist;
  longint edge_n = 0;

  function automatic mdl_t mreset();
    mdl_t r;
    r.mode = 0; r.rise_t = 0; r.fall_t = 0; r.last_p = 0; r.last_h = 0;
    return r;
  endfunction

  // Behavioural rules expressed on the edge timestamps of the sampled waveform.
  function automatic void mstep(input mdl_t si, input longint maxc, input bit e,
                                input bit r, input bit f, input longint t,
                                output mdl_t so, output bit push, output exp_t ex);
    so = si; push = 1'b0;
    ex.ovf = 1'b0; ex.p = 0; ex.h = 0;
    if (!e) begin
      so.mode = 0;
    end else if (si.mode == 0) begin
      so.mode = 1;
    end else if (si.mode == 1) begin
      if (r) begin so.mode = 2; so.rise_t = t; end
    end else begin
      if (r) begin
        so.last_p = t - si.rise_t;
        so.last_h = si.fall_t - si.rise_t;
        so.rise_t = t;
        push = 1'b1; ex.p = so.last_p; ex.h = so.last_h;
      end else if (t - si.rise_t == maxc) begin
        so.mode = 1;
        push = 1'b1; ex.ovf = 1'b1; ex.p = si.last_p; ex.h = si.last_h;
      end else if (f) begin
        so.fall_t = t;
      end
    end
  endfunction

  task automatic step_models();
    mdl_t n; bit ph; exp_t ex; bit r; bit f;
    edge_n++;
    if (rst_i) begin
      hist = '0; m16 = mreset(); m4 = mreset();
    end else begin
      hist = {hist[2:0], pwm};
      r = hist[D] & ~hist[D+1];
      f = ~hist[D] & hist[D+1];
      mstep(m16, 65535, en, r, f, edge_n, n, ph, ex); m16 = n; if (ph) q16.push_back(ex);
      mstep(m4, 15, en, r, f, edge_n, n, ph, ex); m4 = n; if (ph) q4.push_back(ex);
    end
  endtask

  task automatic cyc(input bit p, input bit e);
    pwm = p; en = e;
    @(posedge clk_i);
    step_models();
    #1;
  endtask

  task automatic wave(input int P, input int H, input int n, input bit e);
    for (int k = 0; k < n; k++)
      for (int ph = 0; ph < P; ph++)
        cyc(ph < H, e);
  endtask

  task automatic check_one(input string nm, input bit v, input bit o, input longint p,
                           input longint h, input bit have, input exp_t ex);
    n_vec++;
    if (v && o) begin
      n_err++; $display("FAIL %s both_pulses t=%0t valid=%0b overflow=%0b required one", nm, $time, v, o);
    end else if (!have) begin
      n_err++; $display("FAIL %s unexpected t=%0t valid=%0b overflow=%0b period=%0d high=%0d required none", nm, $time, v, o, p, h);
    end else if (v != !ex.ovf || o != ex.ovf || p != ex.p || h != ex.h) begin
      n_err++;
      $display("FAIL %s report t=%0t got valid=%0b ovf=%0b period=%0d high=%0d required valid=%0b ovf=%0b period=%0d high=%0d",
               nm, $time, v, o, p, h, !ex.ovf, ex.ovf, ex.p, ex.h);
    end else begin
      $display("ok %s t=%0t %s period=%0d high=%0d", nm, $time, o ? "overflow" : "valid", p, h);
    end
  endtask

  // Monitor: whenever a DUT pulses or a prediction is pending, pop and compare.
  initial begin
    exp_t ex; bit have;
    forever begin
      @(negedge clk_i);
      if (bus16.valid_o || bus16.overflow_o || q16.size() > 0) begin
        have = q16.size() > 0;
        ex.ovf = 1'b0; ex.p = 0; ex.h = 0;
        if (have) ex = q16.pop_front();
        if (bus16.valid_o) n_valid_seen++;
        check_one("b16", bus16.valid_o, bus16.overflow_o, longint'(bus16.period_o),
                  longint'(bus16.high_o), have, ex);
      end
      if (bus4.valid_o || bus4.overflow_o || q4.size() > 0) begin
        have = q4.size() > 0;
        ex.ovf = 1'b0; ex.p = 0; ex.h = 0;
        if (have) ex = q4.pop_front();
        if (bus4.overflow_o) n_ovf4_seen++;
        check_one("b4", bus4.valid_o, bus4.overflow_o, longint'(bus4.period_o),
                  longint'(bus4.high_o), have, ex);
      end
    end
  end

  task automatic chk_zero(input string nm);
    n_vec++;
    if (bus16.period_o != 0 || bus16.high_o != 0 || bus16.valid_o || bus16.overflow_o ||
        bus4.period_o != 0 || bus4.high_o != 0 || bus4.valid_o || bus4.overflow_o) begin
      n_err++;
      $display("FAIL %s outputs p16=%0d h16=%0d v16=%0b o16=%0b p4=%0d h4=%0d v4=%0b o4=%0b required all 0",
               nm, bus16.period_o, bus16.high_o, bus16.valid_o, bus16.overflow_o,
               bus4.period_o, bus4.high_o, bus4.valid_o, bus4.overflow_o);
    end else begin
      $display("ok %s outputs zero t=%0t", nm, $time);
    end
  endtask

  initial begin
    int P; int H;
    rst_i = 1'b1; pwm = 1'b0; en = 1'b0; hist = '0;
    m16 = mreset(); m4 = mreset();
    repeat (3) cyc(0, 0);
    chk_zero("reset");
    rst_i = 1'b0;
    cyc(0, 0);
    cyc(0, 1);

    // Steady waveform, then a change mid-run.
    wave(10, 3, 6, 1);
    wave(7, 6, 5, 1);
    // Period equal to the 4-bit maximum: the rise beats the overflow.
    wave(15, 1, 4, 1);
    // 100% duty: the 4-bit instance saturates. Then 0% duty.
    repeat (40) cyc(1, 1);
    repeat (20) cyc(0, 1);
    // Single-cycle high pulses.
    wave(9, 1, 4, 1);

    // Enable dropped for 5 cycles mid-period.
    repeat (3) cyc(1, 1);
    cyc(1, 0); cyc(1, 0); cyc(0, 0); cyc(0, 0); cyc(0, 0);
    wave(10, 4, 5, 1);

    // Randomized waveforms with occasional enable drops.
    for (int i = 0; i < 30; i++) begin
      P = int'($urandom_range(2, 20));
      H = int'($urandom_range(1, P - 1));
      wave(P, H, int'($urandom_range(1, 4)), 1);
      if ($urandom_range(0, 5) == 0) begin
        for (int k = 0; k < int'($urandom_range(1, 6)); k++) cyc(pwm, 0);
      end
    end

    // Asynchronous reset in the middle of the high time.
    wave(10, 4, 3, 1);
    cyc(1, 1); cyc(1, 1);
    #1;
    rst_i = 1'b1;
    q16.delete(); q4.delete();
    m16 = mreset(); m4 = mreset(); hist = '0;
    #1;
    chk_zero("async_rst");
    cyc(1, 1); cyc(0, 1);
    rst_i = 1'b0;
    cyc(0, 1); cyc(0, 1);
    wave(10, 4, 5, 1);
    repeat (5) cyc(0, 1);
    @(negedge clk_i);
    #1;

    n_vec++;
    if (q16.size() != 0 || q4.size() != 0) begin
      n_err++; $display("FAIL drain pending16=%0d pending4=%0d required 0", q16.size(), q4.size());
    end
    n_vec++;
    if (n_valid_seen < 20) begin
      n_err++; $display("FAIL valid_count got=%0d required >=20", n_valid_seen);
    end
    n_vec++;
    if (n_ovf4_seen < 1) begin
      n_err++; $display("FAIL ovf4_count got=%0d required >=1", n_ovf4_seen);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
